// File: rtl/conv_layer_sequencer_if.sv
// Instruction channel between the AXI-Lite instruction/config registers and
// the convolution layer sequencer. The register side is the master, the
// sequencer is the slave.
interface conv_layer_sequencer_if #(
    parameter int INST_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [4:0]            cfg_kernel_size;
    logic [CNT_WIDTH-1:0]  cfg_num_windows;

    modport master (
        output inst,
        output inst_valid,
        output cfg_kernel_size,
        output cfg_num_windows,
        input  inst_ready
    );

    modport slave (
        input  inst,
        input  inst_valid,
        input  cfg_kernel_size,
        input  cfg_num_windows,
        output inst_ready
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: accepts COMPUTE / LOADIFMAPS instructions and
// drives the datapath controls for one layer pass: BRAM address reset, weight
// row fetch over ports A/B, weight commit, ifmap streaming and psum drain.
module conv_layer_sequencer #(
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 1024,
    parameter int INST_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_layer_sequencer_if.slave inst_if,
    input  logic                 weight_from_bram_valid,
    input  logic                 ifmaps_fifo_empty,
    input  logic                 psum_valid,
    output logic                 address_reset,
    output logic                 bram_control_add1,
    output logic                 bram_control_add2,
    output logic                 port_sel,
    output logic                 load_weight_preload,
    output logic                 load_weight,
    output logic                 load_ifmaps,
    output logic                 operation,
    output logic [4:0]           kernel_size,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [INST_WIDTH-1:0] INST_COMPUTE    = INST_WIDTH'(87);
    localparam logic [INST_WIDTH-1:0] INST_LOADIFMAPS = INST_WIDTH'(88);

    localparam int                   TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]        T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]        T_ONE   = TW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ADDR,
        S_W_WAIT,
        S_W_LATCH,
        S_W_ADV,
        S_W_COMMIT,
        S_IF_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           r_q, r_d;               // weight row index, K <= 5
    logic [4:0]           k_q, k_d;               // latched kernel size
    logic [CNT_WIDTH-1:0] n_q, n_d;               // latched window count
    logic [CNT_WIDTH-1:0] w_q, w_d;               // ifmap loads issued
    logic [CNT_WIDTH-1:0] p_q, p_d;               // psums received
    logic [TW-1:0]        t_q, t_d;               // cycles spent in a waiting state
    logic                 weights_loaded_q, weights_loaded_d;
    logic                 err_q, err_d;

    logic                 k_legal;
    logic                 n_nonzero;
    logic                 psum_take;

    assign k_legal     = (inst_if.cfg_kernel_size >= 5'd1) && (inst_if.cfg_kernel_size <= 5'd5);
    assign n_nonzero   = (inst_if.cfg_num_windows != '0);
    assign psum_take   = psum_valid && (p_q < n_q);
    assign kernel_size = k_q;
    assign err         = err_q;

    // State and counter registers; reset abandons any pass without done/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            r_q              <= '0;
            k_q              <= '0;
            n_q              <= '0;
            w_q              <= '0;
            p_q              <= '0;
            t_q              <= '0;
            weights_loaded_q <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            r_q              <= r_d;
            k_q              <= k_d;
            n_q              <= n_d;
            w_q              <= w_d;
            p_q              <= p_d;
            t_q              <= t_d;
            weights_loaded_q <= weights_loaded_d;
            err_q            <= err_d;
        end
    end

    // Next-state logic and decoded datapath controls.
    always_comb begin
        state_d             = state_q;
        r_d                 = r_q;
        k_d                 = k_q;
        n_d                 = n_q;
        w_d                 = w_q;
        p_d                 = p_q;
        weights_loaded_d    = weights_loaded_q;
        err_d               = 1'b0;
        t_d                 = '0;

        inst_if.inst_ready  = 1'b0;
        address_reset       = 1'b0;
        bram_control_add1   = 1'b0;
        bram_control_add2   = 1'b0;
        port_sel            = 1'b0;
        load_weight_preload = 1'b0;
        load_weight         = 1'b0;
        load_ifmaps         = 1'b0;
        operation           = 1'b0;
        busy                = (state_q != S_IDLE);
        done                = 1'b0;

        case (state_q)
            S_IDLE: begin
                inst_if.inst_ready = 1'b1;
                if (inst_if.inst_valid) begin
                    if ((inst_if.inst == INST_COMPUTE) && k_legal && n_nonzero) begin
                        k_d     = inst_if.cfg_kernel_size;
                        n_d     = inst_if.cfg_num_windows;
                        state_d = S_RST_ADDR;
                    end else if ((inst_if.inst == INST_LOADIFMAPS) && weights_loaded_q && n_nonzero) begin
                        // Weights already sit in the MACs; go straight to streaming.
                        n_d     = inst_if.cfg_num_windows;
                        w_d     = '0;
                        p_d     = '0;
                        state_d = S_IF_LOAD;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end

            S_RST_ADDR: begin
                address_reset = 1'b1;
                r_d           = '0;
                state_d       = S_W_WAIT;
            end

            S_W_WAIT: begin
                // Even rows live on port A, odd rows on port B.
                port_sel = r_q[0];
                if (weight_from_bram_valid) begin
                    state_d = S_W_LATCH;
                end else if (t_q == T_LAST) begin
                    err_d            = 1'b1;
                    weights_loaded_d = 1'b0;
                    state_d          = S_IDLE;
                end
            end

            S_W_LATCH: begin
                port_sel            = r_q[0];
                load_weight_preload = 1'b1;
                if ({2'b00, r_q} == (k_q - 5'd1)) begin
                    state_d = S_W_COMMIT;
                end else if (r_q[0]) begin
                    // Both ports consumed: step the pair forward before the next row.
                    state_d = S_W_ADV;
                end else begin
                    r_d     = r_q + 3'd1;
                    state_d = S_W_WAIT;
                end
            end

            S_W_ADV: begin
                bram_control_add2 = 1'b1;
                r_d               = r_q + 3'd1;
                state_d           = S_W_WAIT;
            end

            S_W_COMMIT: begin
                load_weight       = 1'b1;
                // An odd K ends on port A; nudge it to K so the row count is visible.
                bram_control_add1 = k_q[0];
                weights_loaded_d  = 1'b1;
                w_d               = '0;
                p_d               = '0;
                state_d           = S_IF_LOAD;
            end

            S_IF_LOAD: begin
                operation   = 1'b1;
                load_ifmaps = !ifmaps_fifo_empty && (w_q < n_q);
                if (psum_take) begin
                    p_d = p_q + CNT_ONE;
                end
                if (load_ifmaps) begin
                    w_d = w_q + CNT_ONE;
                    if ((w_q + CNT_ONE) == n_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                operation = 1'b1;
                if (psum_take) begin
                    p_d = p_q + CNT_ONE;
                end
                if (p_q == n_q) begin
                    state_d = S_DONE;
                end else if (t_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timeout counter only runs while parked in a waiting state.
        if ((state_d == state_q) && ((state_q == S_W_WAIT) || (state_q == S_DRAIN))) begin
            t_d = t_q + T_ONE;
        end
    end

endmodule
